router_output_arbiter: RTL and testbench
========================================

# router_output_arbiter

Downstream neighbour of the cross-router input queues. Merges `N_INPUTS` AXI-Stream queue outputs onto one router output port and arbitrates per packet. Queues whose `half_full` is raised get priority, with round-robin inside each priority class. The winner stays locked until its `TLAST` beat is taken. The merged stream is driven through a one-beat output register, and a saturating stall counter feeds the PMUs.

## Interface
Parameters:
- `N_INPUTS`, 4 — number of queues merged; ≥2.
- `AXIS_DATA_WIDTH`, 32 — TDATA width.
- `ID_WIDTH` / `DEST_WIDTH` / `USER_WIDTH`, 4 — present only under `TID_PRESENT` / `TDEST_PRESENT` / `TUSER_PRESENT`.
- `STALL_CNT_WIDTH`, 16 — width of the PMU stall counter.

Ports:
- `clk_i`  in  1  sole clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_mosi_i`  in  `axis_mosi_t [N_INPUTS]`  queue outputs; `.data.TLAST` marks the end of a packet.
- `in_miso_o`  out  `axis_miso_t [N_INPUTS]`  per-queue TREADY.
- `half_full_i`  in  `N_INPUTS`  queue half-full flags (urgency).
- `out_mosi_o`  out  `axis_mosi_t`  merged stream, registered.
- `out_miso_i`  in  `axis_miso_t`  downstream TREADY.
- `grant_o`  out  `N_INPUTS`  one-hot current owner; 0 when idle.
- `stall_cnt_o`  out  `STALL_CNT_WIDTH`  cycles with output TVALID=1 and TREADY=0, saturating.
- `stall_clr_i`  in  1  synchronous clear of `stall_cnt_o`.

## Operation
- FSM states:
  - IDLE: if any `in_mosi_i[k].TVALID`, pick a winner.
    - Candidates are TVALID inputs with `half_full_i` set; if none, all TVALID inputs.
    - Winner is the first candidate at or after `rr_ptr`, scanning upward with wrap.
    - Register `grant_o`, then go to LOCKED.
  - LOCKED: the granted input's `TREADY = !out_valid_q || out_miso_i.TREADY`. All other inputs have `TREADY=0`.
    - Each accepted beat is loaded into the output register.
    - When the accepted beat has `TLAST=1`: `rr_ptr ← (g+1) mod N_INPUTS`, `grant_o ← 0`, go to IDLE.
- In IDLE, every `in_miso_o[k].TREADY` is 0.
- Output register:
  - Loads when an input beat is accepted.
  - Otherwise clears `out_valid_q` when `out_miso_i.TREADY` is set.
  - Holds data and TVALID stable while stalled (AXI rule).
- Urgency is sampled only in IDLE; it never pre-empts a locked packet.
- Granted input drops TVALID mid-packet: remain LOCKED, emit nothing, no timeout.
- Stall counter:
  - Increments when `out_mosi_o.TVALID && !out_miso_i.TREADY`, saturating at all-ones.
  - `stall_clr_i` wins over increment; the value is 0 the cycle after the clear.
- Single-beat packet (`TLAST` on the first beat): LOCKED lasts exactly one cycle.

## Timing
- Reset values: state IDLE; `rr_ptr=0`; `grant_o=0`; `out_mosi_o.TVALID=0`; all `in_miso_o` TREADY=0; `stall_cnt_o=0`. Data registers are don't-care.
- Reset mid-packet: the packet is dropped. Upstream queues retain the unsent beats, and no partial beat is driven after reset.
- Latency, input TVALID in IDLE at cycle 0:
  - grant registered at edge 1;
  - beat accepted in cycle 1;
  - `out_mosi_o.TVALID` high in cycle 2.
- Throughput:
  - 1 beat/cycle within a packet when downstream is always ready.
  - Exactly one idle (arbitration) cycle between packets.
- Output stall: TREADY to the granted input drops in the same cycle combinationally; no beat is lost or duplicated.

## Structure
- Shared `noc_pkg`: `axis_mosi_t`, `axis_miso_t`, `axis_data_t` (already used by the queue); add `arb_state_e {IDLE, LOCKED}`.
- One sub-module, `rr_priority_picker`:
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant and valid.
  - Purely combinational; instantiated once on the urgent mask and once on the full mask, with the mux selected by "any urgent".
- The FSM, output register and stall counter stay in the top module.

## Test plan
- **Single packet.** Reset; input 2 sends 3 beats (`TLAST` on the 3rd), output always ready.
  - `grant_o=4'b0100` from cycle 1; out TVALID in cycles 2–4 with data in order.
  - `grant_o=0` and `rr_ptr=3` afterwards.
- **Round-robin fairness.** All 4 inputs continuously send 1-beat packets, no half_full.
  - Grants cycle 0,1,2,3,0… with one bubble between grants.
- **Urgency.** Inputs 0 and 3 valid, `half_full_i=4'b1000`, `rr_ptr=0`.
  - Input 3 is granted first; input 0 is granted next.
- **Backpressure.** During a 4-beat packet, hold `out_miso_i.TREADY=0` for 5 cycles.
  - Output data is stable; `stall_cnt_o` rises by 5; no beat is lost.
- **Saturation and clear.** With `STALL_CNT_WIDTH=4`, stall for 20 cycles.
  - Counter reads 15; after one cycle of `stall_clr_i` it reads 0.
- **Mid-packet reset.** Assert `rst_i` during beat 2 of 4.
  - Next cycle all outputs are at reset values; a new arbitration starts from input 0.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared AXI-Stream types for the router datapath and the output
// arbiter FSM state encoding.
//   axis_data_t  : TDATA/TLAST/TID/TDEST/TUSER payload of one beat
//   axis_mosi_t  : TVALID + payload (producer to consumer)
//   axis_miso_t  : TREADY (consumer to producer)
//   arb_state_e  : output arbiter states
package noc_pkg;

   localparam int unsigned AXIS_DATA_WIDTH = 32;
   localparam int unsigned ID_WIDTH        = 4;
   localparam int unsigned DEST_WIDTH      = 4;
   localparam int unsigned USER_WIDTH      = 4;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0] TDATA;
      logic                       TLAST;
      logic [ID_WIDTH-1:0]        TID;
      logic [DEST_WIDTH-1:0]      TDEST;
      logic [USER_WIDTH-1:0]      TUSER;
   } axis_data_t;

   typedef struct packed {
      logic       TVALID;
      axis_data_t data;
   } axis_mosi_t;

   typedef struct packed {
      logic TREADY;
   } axis_miso_t;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_e;

endpackage

// File: rtl/router_output_arbiter_picker.sv
// rr_priority_picker: combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index where the upward, wrapping scan begins
//   gnt_o   : one-hot grant of the first request at or after ptr_i
//   valid_o : at least one request present
module rr_priority_picker #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   logic [PW-1:0] idx;

   always_comb begin
      gnt_o   = '0;
      valid_o = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PW'((32'(ptr_i) + i) % N);
         if (!valid_o && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            valid_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_output_arbiter.sv
// router_output_arbiter: merges N_INPUTS AXI-Stream queue outputs onto one
// output port with per-packet arbitration (half-full queues first, round-robin
// within each class), a one-beat output register and a saturating stall counter.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   in_mosi_i      : queue outputs          in_miso_o  : per-queue TREADY
//   half_full_i    : queue urgency flags
//   out_mosi_o     : registered merged stream   out_miso_i : downstream TREADY
//   grant_o        : one-hot current owner, 0 when idle
//   stall_cnt_o    : cycles with output TVALID && !TREADY (saturating)
//   stall_clr_i    : synchronous clear of stall_cnt_o
module router_output_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned N_INPUTS        = 4,
   parameter int unsigned STALL_CNT_WIDTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  axis_mosi_t                 in_mosi_i [N_INPUTS],
   output axis_miso_t                 in_miso_o [N_INPUTS],
   input  logic [N_INPUTS-1:0]        half_full_i,
   output axis_mosi_t                 out_mosi_o,
   input  axis_miso_t                 out_miso_i,
   output logic [N_INPUTS-1:0]        grant_o,
   output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o,
   input  logic                       stall_clr_i
);

   localparam int unsigned PW = $clog2(N_INPUTS);

   arb_state_e                 state_q;
   logic [N_INPUTS-1:0]        grant_q;
   logic [PW-1:0]              rr_ptr_q;
   axis_mosi_t                 out_q;
   logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

   logic [N_INPUTS-1:0] valid_vec, gnt_urg, gnt_all, pick;
   logic                any_urg, any_req;
   axis_data_t          sel_beat;
   logic                sel_valid, out_ready, beat_ready, accept;
   logic [PW-1:0]       g_idx, rr_ptr_nxt;

   always_comb begin
      valid_vec = '0;
      for (int unsigned k = 0; k < N_INPUTS; k++) valid_vec[k] = in_mosi_i[k].TVALID;
   end

   rr_priority_picker #(.N(N_INPUTS), .PW(PW)) u_pick_urg (
      .req_i  (valid_vec & half_full_i),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (gnt_urg),
      .valid_o(any_urg)
   );

   rr_priority_picker #(.N(N_INPUTS), .PW(PW)) u_pick_all (
      .req_i  (valid_vec),
      .ptr_i  (rr_ptr_q),
      .gnt_o  (gnt_all),
      .valid_o(any_req)
   );

   assign pick = any_urg ? gnt_urg : gnt_all;

   // Beat and TVALID of the current owner; zero when idle.
   always_comb begin
      sel_beat  = '0;
      sel_valid = 1'b0;
      g_idx     = '0;
      for (int unsigned k = 0; k < N_INPUTS; k++) begin
         if (grant_q[k]) begin
            sel_beat  = in_mosi_i[k].data;
            sel_valid = in_mosi_i[k].TVALID;
            g_idx     = PW'(k);
         end
      end
   end

   assign rr_ptr_nxt = (g_idx == PW'(N_INPUTS - 1)) ? '0 : g_idx + PW'(1);

   // TREADY is withheld while rst_i is high so a beat presented during reset
   // stays in its queue instead of being popped and discarded.
   assign out_ready  = !out_q.TVALID || out_miso_i.TREADY;
   assign beat_ready = (state_q == LOCKED) && out_ready && !rst_i;
   assign accept     = beat_ready && sel_valid;

   always_comb begin
      for (int unsigned k = 0; k < N_INPUTS; k++) begin
         in_miso_o[k]        = '0;
         in_miso_o[k].TREADY = beat_ready && grant_q[k];
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (stall_clr_i)
         stall_d = '0;
      else if (out_q.TVALID && !out_miso_i.TREADY && (stall_q != '1))
         stall_d = stall_q + STALL_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         out_q    <= '0;
         stall_q  <= '0;
      end else begin
         stall_q <= stall_d;

         if (accept) begin
            out_q.TVALID <= 1'b1;
            out_q.data   <= sel_beat;
         end else if (out_miso_i.TREADY) begin
            out_q.TVALID <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_q <= pick;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (accept && sel_beat.TLAST) begin
                  grant_q  <= '0;
                  rr_ptr_q <= rr_ptr_nxt;
                  state_q  <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_mosi_o  = out_q;
   assign grant_o     = grant_q;
   assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// tb_router_output_arbiter: directed bench for router_output_arbiter with
// N_INPUTS=4 and a 4-bit stall counter. Each queue is modelled as a small beat
// list that advances on an accepted handshake; output beats are logged.
module tb_router_output_arbiter;
   import noc_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   axis_mosi_t in_mosi [4];
   axis_miso_t in_miso [4];
   logic [3:0] half_full = '0;
   axis_mosi_t out_mosi;
   axis_miso_t out_miso;
   logic [3:0] grant;
   logic [3:0] stall_cnt;
   logic       stall_clr = 1'b0;

   router_output_arbiter #(.N_INPUTS(4), .STALL_CNT_WIDTH(4)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .in_mosi_i  (in_mosi),
      .in_miso_o  (in_miso),
      .half_full_i(half_full),
      .out_mosi_o (out_mosi),
      .out_miso_i (out_miso),
      .grant_o    (grant),
      .stall_cnt_o(stall_cnt),
      .stall_clr_i(stall_clr)
   );

   always #5 clk = ~clk;

   int          nvec = 0;
   int          nmiss = 0;
   logic [31:0] src_d [4][8];
   bit          src_l [4][8];
   int          src_len [4];
   int          src_idx [4];
   logic [32:0] got_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nmiss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] tready_vec();
      logic [3:0] r;
      for (int k = 0; k < 4; k++) r[k] = in_miso[k].TREADY;
      return r;
   endfunction

   task automatic drive();
      for (int k = 0; k < 4; k++) begin
         in_mosi[k] = '0;
         if (src_idx[k] < src_len[k]) begin
            in_mosi[k].TVALID     = 1'b1;
            in_mosi[k].data.TDATA = src_d[k][src_idx[k]];
            in_mosi[k].data.TLAST = src_l[k][src_idx[k]];
         end
      end
   endtask

   // Queue k gets n beats base+0..base+n-1, TLAST on every beat when single,
   // otherwise only on the last one.
   task automatic load(input int k, input int n, input logic [31:0] base, input bit single);
      for (int i = 0; i < n; i++) begin
         src_d[k][i] = base + 32'(i);
         src_l[k][i] = single || (i == n - 1);
      end
      src_len[k] = n;
      src_idx[k] = 0;
   endtask

   task automatic tick();
      bit hs [4];
      @(negedge clk);
      for (int k = 0; k < 4; k++) hs[k] = in_mosi[k].TVALID && in_miso[k].TREADY;
      if (out_mosi.TVALID && out_miso.TREADY)
         got_q.push_back({out_mosi.data.TLAST, out_mosi.data.TDATA});
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) if (hs[k]) src_idx[k]++;
      drive();
      #1;
   endtask

   logic [3:0]  rr_exp  [8] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100,
                                4'b1000, 4'b0001, 4'b0010, 4'b0100};
   logic [31:0] rr_data [8] = '{32'h40, 32'h10, 32'h20, 32'h30,
                                32'h41, 32'h11, 32'h21, 32'h31};

   initial begin
      out_miso.TREADY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         src_len[k] = 0;
         src_idx[k] = 0;
      end
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset state
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_outvalid", 32'(out_mosi.TVALID), 32'h0);
      chk("rst_stall", 32'(stall_cnt), 32'h0);
      chk("rst_tready", 32'(tready_vec()), 32'h0);

      // Single 3-beat packet on input 2
      load(2, 3, 32'hA0, 1'b0);
      drive();
      #1;
      chk("sp_idle_tready", 32'(tready_vec()), 32'h0);
      tick();
      chk("sp_c1_grant", 32'(grant), 32'h4);
      chk("sp_c1_tready", 32'(tready_vec()), 32'h4);
      chk("sp_c1_outvalid", 32'(out_mosi.TVALID), 32'h0);
      tick();
      chk("sp_c2_outvalid", 32'(out_mosi.TVALID), 32'h1);
      chk("sp_c2_data", out_mosi.data.TDATA, 32'hA0);
      tick();
      chk("sp_c3_data", out_mosi.data.TDATA, 32'hA1);
      chk("sp_c3_grant", 32'(grant), 32'h4);
      tick();
      chk("sp_c4_data", out_mosi.data.TDATA, 32'hA2);
      chk("sp_c4_last", 32'(out_mosi.data.TLAST), 32'h1);
      chk("sp_c4_grant", 32'(grant), 32'h0);
      tick();
      chk("sp_c5_outvalid", 32'(out_mosi.TVALID), 32'h0);
      got_q.delete();

      // Round-robin, all inputs with two single-beat packets; pointer is 3
      for (int k = 0; k < 4; k++) load(k, 2, 32'h10 * (k + 1), 1'b1);
      drive();
      #1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rr_grant", 32'(grant), 32'(rr_exp[i]));
         tick();
         chk("rr_bubble", 32'(grant), 32'h0);
      end
      repeat (2) tick();
      chk("rr_count", 32'(got_q.size()), 32'd8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_q.size()) chk("rr_order", got_q[i][31:0], rr_data[i]);
      end
      got_q.delete();

      // Backpressure: 4-beat packet on input 1, downstream stalled 5 cycles
      load(1, 4, 32'hB0, 1'b0);
      drive();
      #1;
      tick();
      chk("bp_grant", 32'(grant), 32'h2);
      tick();
      chk("bp_first", out_mosi.data.TDATA, 32'hB0);
      out_miso.TREADY = 1'b0;
      #1;
      chk("bp_tready_drop", 32'(tready_vec()), 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", 32'(out_mosi.TVALID), 32'h1);
         chk("bp_hold_data", out_mosi.data.TDATA, 32'hB0);
         tick();
      end
      chk("bp_stall5", 32'(stall_cnt), 32'd5);
      out_miso.TREADY = 1'b1;
      #1;
      chk("bp_tready_back", 32'(tready_vec()), 32'h2);
      repeat (6) tick();
      chk("bp_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_q.size()) chk("bp_order", got_q[i][31:0], 32'hB0 + 32'(i));
      end
      chk("bp_stall_keep", 32'(stall_cnt), 32'd5);
      got_q.delete();

      // Saturation and clear of the 4-bit stall counter
      load(0, 1, 32'hC0, 1'b1);
      drive();
      #1;
      tick();
      chk("sat_grant", 32'(grant), 32'h1);
      tick();
      out_miso.TREADY = 1'b0;
      #1;
      repeat (20) tick();
      chk("sat_15", 32'(stall_cnt), 32'd15);
      chk("sat_data", out_mosi.data.TDATA, 32'hC0);
      stall_clr = 1'b1;
      tick();
      stall_clr = 1'b0;
      #1;
      chk("sat_clr", 32'(stall_cnt), 32'd0);
      tick();
      chk("sat_recount", 32'(stall_cnt), 32'd1);
      out_miso.TREADY = 1'b1;
      #1;
      repeat (3) tick();
      chk("sat_count", 32'(got_q.size()), 32'd1);
      got_q.delete();

      // Mid-packet reset during beat 2 of 4 on input 2 (pointer is 1 here)
      load(2, 4, 32'hD0, 1'b0);
      drive();
      #1;
      tick();
      chk("mr_grant", 32'(grant), 32'h4);
      tick();
      rst = 1'b1;
      #1;
      chk("mr_tready_inrst", 32'(tready_vec()), 32'h0);
      tick();
      chk("mr_grant0", 32'(grant), 32'h0);
      chk("mr_outvalid0", 32'(out_mosi.TVALID), 32'h0);
      chk("mr_tready0", 32'(tready_vec()), 32'h0);
      chk("mr_stall0", 32'(stall_cnt), 32'h0);
      rst = 1'b0;
      src_len[2] = 0;
      src_idx[2] = 0;
      load(0, 1, 32'hE0, 1'b1);
      load(1, 1, 32'hE1, 1'b1);
      drive();
      #1;
      tick();
      chk("mr_new_arb", 32'(grant), 32'h1);
      tick();
      chk("mr_bubble", 32'(grant), 32'h0);
      tick();
      chk("mr_next", 32'(grant), 32'h2);
      repeat (3) tick();

      // Urgency: inputs 0 and 3 valid, only 3 half-full, pointer reset to 0
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      load(0, 1, 32'hF0, 1'b1);
      load(3, 1, 32'hF3, 1'b1);
      half_full = 4'b1000;
      drive();
      #1;
      tick();
      chk("urg_first", 32'(grant), 32'h8);
      tick();
      chk("urg_bubble", 32'(grant), 32'h0);
      tick();
      chk("urg_second", 32'(grant), 32'h1);
      half_full = '0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
      $finish;
   end

endmodule
